// File: rtl/reg_bank_mp.sv
// ---------------------------------------------------------------------------
// reg_bank_mp
//
// Parametrised single-clock register bank: one write port, NUM_RD registered
// read ports with per-port valid, and a hardware clear engine that sweeps the
// array to zero after reset or on request.
//
// Optional feature macro: REG_BANK_MP_WR_BYPASS_EN
//   defined   : a read of the address accepted for write in the same cycle
//               returns data_inA (write-first)
//   undefined : the same read returns the pre-write word (read-first)
//
// Ports
//   CLK        in   1               sole clock, rising edge
//   RST        in   1               synchronous active-high reset
//   weA        in   1               write enable
//   addrA      in   ADDR_W          write address
//   data_inA   in   DATA_W          write data
//   wr_err     out  1               one-cycle pulse: previous write rejected
//   reB        in   NUM_RD          per-port read enable
//   addrB      in   NUM_RD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   data_outB  out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//   validB     out  NUM_RD          per-port read-data valid
//   clr_req    in   1               request full-array clear
//   busy       out  1               clear sweep in progress
// ---------------------------------------------------------------------------
module reg_bank_mp #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     weA,
   input  logic [ADDR_W-1:0]        addrA,
   input  logic [DATA_W-1:0]        data_inA,
   output logic                     wr_err,
   input  logic [NUM_RD-1:0]        reB,
   input  logic [NUM_RD*ADDR_W-1:0] addrB,
   output logic [NUM_RD*DATA_W-1:0] data_outB,
   output logic [NUM_RD-1:0]        validB,
   input  logic                     clr_req,
   output logic                     busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // One extra bit so DEPTH == 2**ADDR_W is representable in range checks.
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ADDR_W-1:0]          r_clr_ptr;
   logic [ADDR_W-1:0]          w_clr_ptr_nxt;

   logic [DATA_W-1:0]          r_mem [DEPTH];

   logic                       w_wr_ok;
   logic                       r_wr_err;
   logic [DATA_W-1:0]          w_rd_word [NUM_RD];
   logic [NUM_RD*DATA_W-1:0]   r_data_out;
   logic [NUM_RD-1:0]          r_valid;

   // ------------------------------------------------------------------------
   // Clear-sweep FSM
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_ptr_nxt = '0;
            end
         end
         ST_CLEAR: begin
            // clr_req is deliberately not looked at here: a request during a
            // sweep neither restarts nor queues another one.
            if (r_clr_ptr == LP_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            end
         end
      endcase
   end

   assign busy = (r_state == ST_CLEAR);

   // ------------------------------------------------------------------------
   // Write port
   // ------------------------------------------------------------------------
   // A write is only taken when no sweep is running and the address exists.
   // During reset nothing is written; the following sweep clears the array.
   assign w_wr_ok = weA && !RST && (r_state == ST_IDLE) && ({1'b0, addrA} < LP_DEPTH);

   // NOTE: the array has no reset; it is zeroed by the sweep instead, which
   // keeps it mappable onto plain RAM/flop arrays without a reset tree.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
         end else if (w_wr_ok) begin
            // A write together with clr_req lands now and is swept later.
            r_mem[addrA] <= data_inA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= weA && !w_wr_ok;
      end
   end

   assign wr_err = r_wr_err;

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   // Word returned for each port: zero while sweeping or out of range,
   // otherwise the stored word (or the incoming write data when bypassing).
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         w_rd_word[i] = '0;
         if ((r_state == ST_IDLE) && ({1'b0, addrB[i*ADDR_W +: ADDR_W]} < LP_DEPTH)) begin
`ifdef REG_BANK_MP_WR_BYPASS_EN
            if (w_wr_ok && (addrA == addrB[i*ADDR_W +: ADDR_W])) begin
               w_rd_word[i] = data_inA;
            end else begin
               w_rd_word[i] = r_mem[addrB[i*ADDR_W +: ADDR_W]];
            end
`else
            // Memory is read before the edge that commits a same-cycle
            // write, so the pre-write word is returned.
            w_rd_word[i] = r_mem[addrB[i*ADDR_W +: ADDR_W]];
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_data_out <= '0;
         r_valid    <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            r_valid[i] <= reB[i];
            // Data holds its last value on idle ports; only valid drops.
            if (reB[i]) begin
               r_data_out[i*DATA_W +: DATA_W] <= w_rd_word[i];
            end
         end
      end
   end

   assign data_outB = r_data_out;
   assign validB    = r_valid;

endmodule

// File: tb/tb_reg_bank_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_mp
//
// Self-checking bench for reg_bank_mp. Main instance uses DEPTH=16; a second
// instance with DEPTH=12 covers out-of-range addresses inside ADDR_W.
// Expected values come from a behavioural model: an array of words plus a
// count of remaining sweep cycles.
// ---------------------------------------------------------------------------
module tb_reg_bank_mp;

   localparam int DW = 8;
   localparam int D  = 16;
   localparam int AW = 4;
   localparam int NR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (DEPTH=16)
   logic             rst = 1'b1;
   logic             we = 1'b0;
   logic [AW-1:0]    addr_a = '0;
   logic [DW-1:0]    din = '0;
   logic             wr_err;
   logic [NR-1:0]    re = '0;
   logic [NR*AW-1:0] addr_b = '0;
   logic [NR*DW-1:0] dout;
   logic [NR-1:0]    valid;
   logic             clr = 1'b0;
   logic             busy;

   // Second instance (DEPTH=12)
   logic             rst_s = 1'b1;
   logic             we_s = 1'b0;
   logic [AW-1:0]    addr_a_s = '0;
   logic [DW-1:0]    din_s = '0;
   logic             wr_err_s;
   logic [NR-1:0]    re_s = '0;
   logic [NR*AW-1:0] addr_b_s = '0;
   logic [NR*DW-1:0] dout_s;
   logic [NR-1:0]    valid_s;
   logic             clr_s = 1'b0;
   logic             busy_s;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [DW-1:0]    m_mem [D];
   int               sweep_left = D;
   logic [NR*DW-1:0] exp_data  = '0;
   logic [NR-1:0]    exp_valid = '0;
   logic             exp_err   = 1'b0;
   logic             exp_busy  = 1'b1;

   reg_bank_mp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
      .CLK(clk), .RST(rst), .weA(we), .addrA(addr_a), .data_inA(din),
      .wr_err(wr_err), .reB(re), .addrB(addr_b), .data_outB(dout),
      .validB(valid), .clr_req(clr), .busy(busy)
   );

   reg_bank_mp #(.DATA_W(DW), .DEPTH(12), .ADDR_W(AW), .NUM_RD(NR)) u_dut12 (
      .CLK(clk), .RST(rst_s), .weA(we_s), .addrA(addr_a_s), .data_inA(din_s),
      .wr_err(wr_err_s), .reB(re_s), .addrB(addr_b_s), .data_outB(dout_s),
      .validB(valid_s), .clr_req(clr_s), .busy(busy_s)
   );

   // Advance the model by one edge using the current inputs, then let the
   // DUT take the same edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      bit            in_clear;
      bit            acc;
      logic [AW-1:0] ra;
      if (rst) begin
         sweep_left = D;
         exp_data   = '0;
         exp_valid  = '0;
         exp_err    = 1'b0;
      end else begin
         in_clear = (sweep_left > 0);
         acc      = we && !in_clear;
         for (int i = 0; i < NR; i++) begin
            exp_valid[i] = re[i];
            if (re[i]) begin
               ra = addr_b[i*AW +: AW];
               if (in_clear) exp_data[i*DW +: DW] = '0;
`ifdef REG_BANK_MP_WR_BYPASS_EN
               else if (acc && ra == addr_a) exp_data[i*DW +: DW] = din;
`endif
               else exp_data[i*DW +: DW] = m_mem[ra];
            end
         end
         exp_err = we && !acc;
         if (acc) m_mem[addr_a] = din;
         if (in_clear) begin
            m_mem[D - sweep_left] = '0;
            sweep_left--;
         end else if (clr) begin
            sweep_left = D;
         end
      end
      exp_busy = (sweep_left > 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we  = 1'b0;
      re  = '0;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || dout !== '0 || valid !== '0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got busy=%b dout=%h valid=%b err=%b exp busy=1 dout=0 valid=0 err=0",
                     c, busy, dout, valid, wr_err);
         end
      end
      rst = 1'b0;
      n = busy ? 1 : 0;
      for (int g = 0; g < 40 && busy === 1'b1; g++) begin
         tick();
         if (busy === 1'b1) n++;
      end
      checks++;
      if (n !== D) begin
         failures++;
         $display("FAIL reset_busy_len got=%0d exp=%0d", n, D);
      end
      for (int a = 0; a < D; a++) begin
         re     = 2'b11;
         addr_b = {4'(D - 1 - a), 4'(a)};
         tick();
         checks++;
         if (dout !== 16'h0000 || valid !== 2'b11) begin
            failures++;
            $display("FAIL reset_read_zero addr=%0d got dout=%h valid=%b exp dout=0000 valid=11", a, dout, valid);
         end
      end
      idle();
   endtask

   task automatic test_multi_read();
      we = 1'b1; addr_a = 4'd3; din = 8'hA5; tick();
      addr_a = 4'd7; din = 8'h5A; tick();
      we = 1'b0; re = 2'b11; addr_b = {4'd7, 4'd3}; tick();
      checks++;
      if (dout !== 16'h5AA5 || valid !== 2'b11) begin
         failures++;
         $display("FAIL multi_read got dout=%h valid=%b exp dout=5aa5 valid=11", dout, valid);
      end
      // Same address on both ports.
      addr_b = {4'd3, 4'd3}; tick();
      checks++;
      if (dout !== 16'hA5A5) begin
         failures++;
         $display("FAIL same_addr_read got=%h exp=a5a5", dout);
      end
      // Disabled ports drop valid but hold data.
      re = 2'b00; tick();
      checks++;
      if (dout !== 16'hA5A5 || valid !== 2'b00) begin
         failures++;
         $display("FAIL read_hold got dout=%h valid=%b exp dout=a5a5 valid=00", dout, valid);
      end
      idle();
   endtask

   task automatic test_blocked();
      we = 1'b1; addr_a = 4'd2; din = 8'h33; tick();
      we = 1'b0; clr = 1'b1; tick();
      clr = 1'b0;
      // Write during busy, with a same-cycle read of that address.
      we = 1'b1; addr_a = 4'd2; din = 8'h77; re = 2'b01; addr_b = {4'd0, 4'd2}; tick();
      checks++;
      if (wr_err !== 1'b1 || dout[7:0] !== 8'h00) begin
         failures++;
         $display("FAIL busy_write_err got err=%b dout0=%h exp err=1 dout0=00", wr_err, dout[7:0]);
      end
      idle(); tick();
      checks++;
      if (wr_err !== 1'b0) begin
         failures++;
         $display("FAIL busy_write_err_pulse got=%b exp=0", wr_err);
      end
      for (int g = 0; g < 40 && busy === 1'b1; g++) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL blocked_sweep_timeout got busy=%b exp=0", busy);
      end
      re = 2'b10; addr_b = {4'd2, 4'd0}; tick();
      checks++;
      if (dout[15:8] !== 8'h00 || valid !== 2'b10) begin
         failures++;
         $display("FAIL busy_write_dropped got=%h valid=%b exp=00 valid=10", dout[15:8], valid);
      end
      idle();
   endtask

   task automatic test_rdw();
      logic [7:0] exp_rdw;
`ifdef REG_BANK_MP_WR_BYPASS_EN
      exp_rdw = 8'h22;
`else
      exp_rdw = 8'h11;
`endif
      we = 1'b1; addr_a = 4'd5; din = 8'h11; tick();
      din = 8'h22; re = 2'b01; addr_b = {4'd0, 4'd5}; tick();
      checks++;
      if (dout[7:0] !== exp_rdw || dout !== exp_data) begin
         failures++;
         $display("FAIL read_during_write got=%h exp=%h (model %h)", dout[7:0], exp_rdw, exp_data);
      end
      we = 1'b0; tick();
      checks++;
      if (dout[7:0] !== 8'h22) begin
         failures++;
         $display("FAIL read_after_write got=%h exp=22", dout[7:0]);
      end
      idle();
   endtask

   task automatic test_clear_req();
      int n;
      for (int a = 0; a < D; a++) begin
         we = 1'b1; addr_a = 4'(a); din = 8'hFF; tick();
      end
      we = 1'b0; clr = 1'b1; tick();
      clr = 1'b0;
      n = busy ? 1 : 0;
      for (int k = 0; k < 40 && busy === 1'b1; k++) begin
         clr    = (k == 3);
         re     = 2'b11;
         addr_b = {4'($urandom_range(0, D - 1)), 4'($urandom_range(0, D - 1))};
         tick();
         if (busy === 1'b1) n++;
         checks++;
         if (dout !== 16'h0000 || valid !== 2'b11) begin
            failures++;
            $display("FAIL clear_read_zero k=%0d got dout=%h valid=%b exp dout=0000 valid=11", k, dout, valid);
         end
      end
      idle();
      checks++;
      if (n !== D) begin
         failures++;
         $display("FAIL clear_busy_len got=%0d exp=%0d", n, D);
      end
      for (int a = 0; a < D; a++) begin
         re = 2'b01; addr_b = {4'd0, 4'(a)}; tick();
         checks++;
         if (dout[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL clear_result addr=%0d got=%h exp=00", a, dout[7:0]);
         end
      end
      idle();
   endtask

   task automatic test_rst_mid_sweep();
      int n;
      for (int a = 0; a < D; a++) begin
         we = 1'b1; addr_a = 4'(a); din = 8'(8'hC0 + a); tick();
      end
      we = 1'b0; clr = 1'b1; tick();
      clr = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      n = busy ? 1 : 0;
      for (int g = 0; g < 40 && busy === 1'b1; g++) begin
         tick();
         if (busy === 1'b1) n++;
      end
      checks++;
      if (n !== D) begin
         failures++;
         $display("FAIL mid_sweep_busy_len got=%0d exp=%0d", n, D);
      end
      for (int a = 0; a < D; a++) begin
         re = 2'b10; addr_b = {4'(a), 4'd0}; tick();
         checks++;
         if (dout[15:8] !== 8'h00) begin
            failures++;
            $display("FAIL mid_sweep_result addr=%0d got=%h exp=00", a, dout[15:8]);
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         we     = ($urandom_range(0, 1) == 1);
         addr_a = 4'($urandom_range(0, D - 1));
         din    = 8'($urandom);
         re     = 2'($urandom);
         addr_b = {4'($urandom_range(0, D - 1)), 4'($urandom_range(0, D - 1))};
         clr    = ($urandom_range(0, 39) == 0);
         tick();
         checks++;
         if (dout !== exp_data || valid !== exp_valid || wr_err !== exp_err || busy !== exp_busy) begin
            failures++;
            $display("FAIL random cyc=%0d got dout=%h valid=%b err=%b busy=%b exp dout=%h valid=%b err=%b busy=%b",
                     c, dout, valid, wr_err, busy, exp_data, exp_valid, exp_err, exp_busy);
         end
      end
      idle();
   endtask

   task automatic test_oob12();
      int n;
      rst_s = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_s = 1'b0;
      n = busy_s ? 1 : 0;
      for (int g = 0; g < 40 && busy_s === 1'b1; g++) begin
         @(posedge clk); #1;
         if (busy_s === 1'b1) n++;
      end
      checks++;
      if (n !== 12) begin
         failures++;
         $display("FAIL d12_busy_len got=%0d exp=12", n);
      end
      we_s = 1'b1; addr_a_s = 4'd13; din_s = 8'h99;
      @(posedge clk); #1;
      checks++;
      if (wr_err_s !== 1'b1) begin
         failures++;
         $display("FAIL d12_oob_write_err got=%b exp=1", wr_err_s);
      end
      addr_a_s = 4'd11; din_s = 8'h3C;
      @(posedge clk); #1;
      checks++;
      if (wr_err_s !== 1'b0) begin
         failures++;
         $display("FAIL d12_last_write_ok got=%b exp=0", wr_err_s);
      end
      we_s = 1'b0; re_s = 2'b11; addr_b_s = {4'd11, 4'd13};
      @(posedge clk); #1;
      checks++;
      if (dout_s !== 16'h3C00 || valid_s !== 2'b11) begin
         failures++;
         $display("FAIL d12_oob_read got dout=%h valid=%b exp dout=3c00 valid=11", dout_s, valid_s);
      end
      re_s = '0;
   endtask

   initial begin
      for (int a = 0; a < D; a++) m_mem[a] = '0;
      #2;
      test_reset();
      test_multi_read();
      test_blocked();
      test_rdw();
      test_clear_req();
      test_rst_mid_sweep();
      test_random();
      test_oob12();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised single-clock register bank with one write port, `NUM_RD` independent read ports and a hardware clear engine. It sweeps the array to zero after reset or on request. It is the general-purpose successor to the fixed 16x8 dual-port bank and sits wherever control or status state needs multi-reader access in a single clock domain. Read ports are registered, with a per-port valid. Illegal or blocked writes are flagged, never silently corrupted.

## Interface
Parameters:
- `DATA_W`, 8, word width in bits (>=1)
- `DEPTH`, 16, number of words (2..2^ADDR_W)
- `ADDR_W`, 4, address width in bits
- `NUM_RD`, 2, number of read ports (>=1)

Ports:
- `CLK`  in  1  sole clock; all logic on its rising edge
- `RST`  in  1  synchronous, active-high reset
- `weA`  in  1  write enable
- `addrA`  in  ADDR_W  write address
- `data_inA`  in  DATA_W  write data
- `wr_err`  out  1  one-cycle pulse: previous-cycle write rejected
- `reB`  in  NUM_RD  per-port read enable
- `addrB`  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `data_outB`  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- `validB`  out  NUM_RD  per-port read-data valid
- `clr_req`  in  1  request full-array clear
- `busy`  out  1  clear sweep in progress

## Operation
- FSM states are IDLE and CLEAR. A 0..DEPTH-1 pointer `clr_ptr` drives the sweep. `busy` = (state == CLEAR).
- RST high at a clock edge:
  - state <= CLEAR, `clr_ptr` <= 0
  - `data_outB` <= 0, `validB` <= 0, `wr_err` <= 0
  - array contents are not touched by reset itself; the sweep clears them.
- CLEAR, on each edge:
  - write 0 to mem[`clr_ptr`]
  - if `clr_ptr` == DEPTH-1: state <= IDLE
  - else `clr_ptr` += 1
- IDLE with `clr_req`=1: state <= CLEAR and `clr_ptr` <= 0. Any `clr_req` seen during CLEAR is ignored; it is neither queued nor restarts the sweep.
- Write acceptance, when `weA`=1:
  - Accepted only if state is IDLE and `addrA` < DEPTH. Then mem[`addrA`] <= `data_inA`.
  - Otherwise the write is dropped and `wr_err` = 1 in the next cycle.
  - A write together with `clr_req` in IDLE is accepted, then overwritten by the sweep.
- Read, when `reB[i]`=1:
  - `data_outB[i]` <= mem[`addrB[i]`] and `validB[i]` <= 1.
  - If `addrB[i]` >= DEPTH, or state is CLEAR, data is 0 and valid is still 1.
- Read with `reB[i]`=0: `validB[i]` <= 0 and `data_outB[i]` holds its last value.
- Multiple ports may read the same address in the same cycle; each returns identical data.
- Read-during-write to the same address: returns the old word by default (see Configuration).

## Timing
- Read latency: 1 cycle, from `reB`/`addrB` sampled at edge N to `data_outB`/`validB` valid after edge N.
- Write latency: a word written at edge N is visible to a read sampled at edge N+1.
- `wr_err`: pulses for exactly one cycle, after the edge that rejected the write.
- Busy time:
  - After RST deasserts, `busy` stays high for exactly DEPTH cycles. It is also high while RST is held.
  - For `clr_req` sampled at edge N, `busy` is high from after edge N through after edge N+DEPTH-1, i.e. DEPTH cycles.
- RST asserted mid-sweep restarts the sweep at pointer 0.

## Configuration
- Macro: `REG_BANK_MP_WR_BYPASS_EN`.
- Defined: a read sampled in the same cycle as an accepted write to the same address returns `data_inA` (write-first). A rejected write never bypasses.
- Undefined: the same read returns the pre-write word (read-first).

## Test plan
- Reset with DEPTH=16: hold RST 3 cycles, release. Required: `busy`=1 for 16 cycles, then 0. All outputs are 0 during RST. Reading every address afterwards returns 0x00 with `validB`=1.
- Multi-port read: write 0xA5 to addr 3 and 0x5A to addr 7. Then `reB`=2'b11 with port0 addr 3 and port1 addr 7. Required: next cycle `data_outB` = {0x5A, 0xA5} and `validB`=2'b11.
- Blocked writes:
  - Write during `busy` -> `wr_err`=1 for one cycle, and a later read shows the word still 0.
  - With DEPTH=12, a write to addr 13 -> `wr_err`=1, and a read of addr 13 returns 0.
- Read-during-write: addr 5 holds 0x11, then write 0x22 to addr 5 and read addr 5 in the same cycle.
  - Required without the macro: 0x11.
  - Required with `REG_BANK_MP_WR_BYPASS_EN`: 0x22.
  - Either way, the next read returns 0x22.
- Clear request: fill all words with 0xFF, pulse `clr_req`, and pulse it again 4 cycles later.
  - Required: `busy` high for exactly 16 cycles; the second request is ignored.
  - Reads during `busy` return 0; all words read 0x00 afterwards.
- Reset mid-sweep: assert RST at sweep pointer 9 for one cycle. Required: `busy` remains high for 16 further cycles after release, and the array ends all zero.
